divide_controller: RTL and testbench
====================================

DIVIDE_CONTROLLER -- requirements
Module: divide_controller

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, reset; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request a new divide; sampled in IDLE only
- sign  input  1  datapath adder MSB, the sign of (Remainder[15:8] - divisor) when add=0
- load  output  1  divisor register load enable
- add  output  1  1 = add, 0 = subtract
- shift  output  1  1 = shift the mux value left by one bit into the remainder register
- inbit  output  1  bit shifted into Remainder[0]; this is the quotient bit
- sel  output  2  datapath mux select: 01 = adder/low half, 10 = {8'h00, dividend}, 11 = hold
- busy  output  1  operation in progress (INIT or ITER)
- done  output  1  one-cycle pulse: quotient and remainder are valid

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, INIT, ITER, DONE, plus a 3-bit iteration counter cnt.
REQ-004 IDLE SHALL drive load=0, add=0, shift=0, inbit=0, sel=11, busy=0, done=0, so the datapath holds its state.
REQ-005 IDLE with start=1 at a rising edge SHALL transition to INIT; IDLE with start=0 SHALL remain in IDLE.
REQ-006 INIT SHALL last exactly one cycle and drive load=1, sel=10, shift=1, inbit=0, add=0, busy=1; this loads the divisor and {8'h00, dividend}<<1.
REQ-007 INIT SHALL clear cnt to 0 and transition to ITER.
REQ-008 ITER SHALL drive load=0, add=0 (subtract), busy=1, shift=1.
REQ-009 In ITER, sel and inbit SHALL be Mealy outputs of the same-cycle sign input:
- sign=0: sel=01, inbit=1 (commit the difference, quotient bit 1)
- sign=1: sel=11, inbit=0 (restore by holding, quotient bit 0)
REQ-010 ITER SHALL increment cnt each cycle, last exactly 8 cycles (cnt 0..7), and transition to DONE when cnt=7.
REQ-011 DONE SHALL last one cycle, drive done=1, busy=0, with the remaining outputs as in IDLE, then transition to IDLE.
REQ-012 start SHALL be ignored in INIT, ITER and DONE; no queuing occurs.
REQ-013 Latency: if start is sampled high at edge k, INIT occupies cycle k+1, ITER occupies k+2..k+9, and done=1 in cycle k+10.
REQ-014 After DONE, quotient = Remainder[7:0] and remainder = Remainder[15:9]; these SHALL remain stable until the next INIT.
REQ-015 If start is held high continuously, the next INIT SHALL follow one IDLE cycle after DONE, for a period of 11 cycles per operation.
REQ-016 A divisor of 0 SHALL run the same 10-cycle sequence and pulse done; the numeric result is don't-care, and the FSM SHALL NOT hang.
REQ-017 No output SHALL ever be X or Z after the first reset; an unreachable state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-018 reset=1 at a rising edge SHALL force state=IDLE, cnt=0, and all outputs to their IDLE values, including done=0 and busy=0.
REQ-019 reset SHALL take priority over start and over any in-progress operation; an operation aborted mid-ITER produces no done pulse.
REQ-020 After reset deasserts, the block SHALL accept start on the first edge it is sampled in IDLE.

Verification
REQ-021 The bench, paired with the datapath, SHALL cover the following directed scenarios:
- dividend=100, divisor=7, start pulse -> done exactly 10 cycles after the start edge; quotient=14, remainder=2
- dividend=255, divisor=1 -> quotient=255, remainder=0; all 8 ITER cycles have sign=0 and inbit=1
- dividend=5, divisor=9 -> quotient=0, remainder=5; all ITER cycles have sign=1, sel=11, inbit=0
- start held high across three operations -> done pulses spaced 11 cycles apart; start pulses during busy produce no extra operation
- reset asserted in the 4th ITER cycle -> next cycle is IDLE with busy=0; no done pulse; a following start of 200/13 gives quotient=15, remainder=5
- divisor=0, any dividend -> done pulses at cycle k+10 and the FSM returns to IDLE

Source files
------------

// File: rtl/divide_controller.sv
// Sequencing FSM for an 8-bit restoring divider.
// It drives the load, mux, shift and quotient-bit controls of an external remainder/divisor datapath.
module divide_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    add     = 1'b0;
    shift   = 1'b0;
    inbit   = 1'b0;
    sel     = 2'b11;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        load    = 1'b1;
        sel     = 2'b10;
        shift   = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        shift = 1'b1;
        busy  = 1'b1;
        // Negative trial difference means restore: hold the shifted remainder and emit a 0 bit.
        if (sign) begin
          sel   = 2'b11;
          inbit = 1'b0;
        end else begin
          sel   = 2'b01;
          inbit = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divide_controller.sv
// Bench for divide_controller.
// It closes the loop through a behavioural remainder/divisor datapath and compares the results against hand-computed quotients.
module tb_divide_controller;

  logic       clk = 1'b0;
  logic       reset, start, sign;
  logic       load, add, shift, inbit, busy, done;
  logic [1:0] sel;

  logic [7:0]  dd, dv;
  logic [15:0] rem_q = '0;
  logic [7:0]  dvs_q = '0;
  logic [8:0]  diff;
  logic [15:0] mux;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divide_controller dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sign  (sign),
    .load  (load),
    .add   (add),
    .shift (shift),
    .inbit (inbit),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  // Datapath: 16-bit remainder register, 8-bit divisor register, and a subtractor on the upper half.
  assign diff = {1'b0, rem_q[15:8]} - {1'b0, dvs_q};
  assign sign = diff[8];
  always_comb begin
    case (sel)
      2'b01:   mux = {diff[7:0], rem_q[7:0]};
      2'b10:   mux = {8'h00, dd};
      default: mux = rem_q;
    endcase
  end
  always @(posedge clk) begin
    if (load) dvs_q <= dv;
    if (shift) rem_q <= {mux[14:0], inbit};
    else       rem_q <= mux;
  end

  typedef struct {
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] q;
    logic [7:0] r;
    int         mode;  // 0 normal, 1 all sign=0, 2 all sign=1, 3 result don't-care
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " load"}, load, 0);
    chk({tag, " shift"}, shift, 0);
    chk({tag, " sel"}, sel, 3);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int iters;
    dd    = v.dividend;
    dv    = v.divisor;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    iters = 0;
    chk("init busy", busy, 1);
    chk("init load", load, 1);
    chk("init sel", sel, 2);
    chk("init shift", shift, 1);
    chk("init inbit", inbit, 0);
    while (!done && lat < 20) begin
      step();
      lat++;
      // Extra start pulses while busy must be ignored.
      start = (lat == 5);
      if (!done) begin
        iters++;
        chk("iter busy", busy, 1);
        chk("iter load", load, 0);
        chk("iter add", add, 0);
        chk("iter shift", shift, 1);
        chk("iter inbit", inbit, !sign);
        chk("iter sel", sel, sign ? 3 : 1);
        if (v.mode == 1) chk("iter sign0", sign, 0);
        if (v.mode == 2) chk("iter sign1", sign, 1);
      end
    end
    start = 1'b0;
    chk("latency", lat, 10);
    chk("iter count", iters, 8);
    chk("done busy", busy, 0);
    if (v.mode != 3) begin
      chk("quotient", rem_q[7:0], v.q);
      chk("remainder", rem_q[15:9], v.r);
    end
    step();
    chk_idle("post");
    step();
    chk_idle("post2");
  endtask

  initial begin
    int dcount;
    int dpos[3];
    int ncyc;
    vec_t v;

    vecs[0] = '{dividend: 8'd100, divisor: 8'd7,  q: 8'd14,  r: 8'd2, mode: 0};
    vecs[1] = '{dividend: 8'd255, divisor: 8'd1,  q: 8'd255, r: 8'd0, mode: 1};
    vecs[2] = '{dividend: 8'd5,   divisor: 8'd9,  q: 8'd0,   r: 8'd5, mode: 2};
    vecs[3] = '{dividend: 8'd200, divisor: 8'd13, q: 8'd15,  r: 8'd5, mode: 0};
    vecs[4] = '{dividend: 8'd77,  divisor: 8'd0,  q: 8'd0,   r: 8'd0, mode: 3};

    reset = 1'b1;
    start = 1'b1;
    dd    = '0;
    dv    = '0;
    step();
    step();
    chk_idle("reset");
    chk("reset inbit", inbit, 0);
    reset = 1'b0;

    // First edge after reset release must accept start.
    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Start held high: three operations with done pulses 11 cycles apart.
    dd     = 8'd100;
    dv     = 8'd7;
    start  = 1'b1;
    dcount = 0;
    ncyc   = 0;
    while (dcount < 3 && ncyc < 40) begin
      step();
      ncyc++;
      if (done) begin
        dpos[dcount] = ncyc;
        dcount++;
        chk("held quotient", rem_q[7:0], 14);
      end
    end
    start = 1'b0;
    chk("held done count", dcount, 3);
    chk("held first done", dpos[0], 10);
    chk("held spacing 1", dpos[1] - dpos[0], 11);
    chk("held spacing 2", dpos[2] - dpos[1], 11);
    step();
    chk_idle("held end");

    // Reset in the 4th ITER cycle aborts without a done pulse.
    dd    = 8'd100;
    dv    = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre-abort busy", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    step();
    chk_idle("abort");
    reset  = 1'b0;
    start  = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) dcount++;
    end
    chk("abort no activity", dcount, 0);
    v = '{dividend: 8'd200, divisor: 8'd13, q: 8'd15, r: 8'd5, mode: 0};
    run_op(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
